matrix_scan_controller: RTL
===========================

MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000, meaning clocks per column phase (legal minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink half-period (legal minimum 1).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scan_en  input  1  scan enable.
REQ-006 in_valid  input  1  glyph request valid.
REQ-007 in_ready  output  1  glyph request can be accepted.
REQ-008 in_glyph  input  4  glyph code.
REQ-009 in_blink  input  1  blink request for the glyph.
REQ-010 ring_counter  output  3  one-hot column phase to the display driver; 000 means all columns off.
REQ-011 col_2  output  7  row image for columns 0 and 4, bit 6 = row 0.
REQ-012 col_1  output  7  row image for columns 1 and 3.
REQ-013 col_0  output  7  row image for column 2.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Phase register SHALL cycle 001 -> 010 -> 100 -> 001; it advances when the dwell counter reaches DWELL_CYCLES-1, then the counter clears.
REQ-016 Frame boundary SHALL be the phase advance 100 -> 001; frame_done SHALL be high for exactly the cycle after that edge.
REQ-017 ring_counter SHALL equal phase when registered enable en_q=1, else 000.
REQ-018 scan_en low SHALL clear the dwell counter, force phase to 001 and en_q to 0; re-enable SHALL start a full new frame at phase 001 with no frame_done pulse.
REQ-019 Accept SHALL occur on in_valid && in_ready; in_ready = !pending_valid (no combinational path from in_valid).
REQ-020 An accepted {glyph, blink} SHALL go to the pending register and set pending_valid.
REQ-021 At a frame boundary with pending_valid=1, pending SHALL move to active and pending_valid SHALL clear; the image changes only at frame boundaries, never mid-frame.
REQ-022 A request accepted on the same edge as a boundary SHALL be held pending until the next boundary.
REQ-023 Pending SHALL be accepted while scan_en=0 but SHALL apply only at a boundary.
REQ-024 Column images SHALL be decoded from the active glyph via a 16-entry ROM; codes 8-15 SHALL decode to blank.
REQ-025 Blink phase bit SHALL toggle every BLINK_FRAMES boundaries (frame counter wraps at BLINK_FRAMES-1); it SHALL clear when a new active glyph is loaded.
REQ-026 col_2/col_1/col_0 SHALL output the decoded image, or 0 when the active blink bit=1 and the blink phase=1.
REQ-027 All outputs except in_ready SHALL be driven from registers; the latency from a boundary to the new image SHALL be 1 cycle, aligned with ring_counter=001.

Reset
REQ-028 Reset SHALL force: phase=001, dwell counter=0, en_q=0, ring_counter=000, cols=0, frame_done=0, active glyph=0 (blank), blink bits=0, frame counter=0, pending_valid=0 (in_ready=1).
REQ-029 Reset asserted mid-frame or with a request pending SHALL discard both; the first post-reset frame SHALL be blank.

Structure
REQ-030 Package matrix_pkg SHALL hold the glyph code constants (0 BLANK, 1 FULL, 2 DROP, 3 ALARM_X, 4 BAR, 5-7 reserved-blank), the ROM contents and the phase constants.
REQ-031 Sub-module matrix_glyph_rom SHALL be purely combinational: 4-bit code in, three 7-bit images out.
REQ-032 Required ROM values: FULL = all 7'h7F; ALARM_X = col_2 7'h41, col_1 7'h22, col_0 7'h1C; BAR = col_2 7'h00, col_1 7'h00, col_0 7'h7F.
REQ-033 Total RTL SHALL fit 120-400 lines.

Verification (DWELL_CYCLES=4, BLINK_FRAMES=2, 12-cycle frame)
REQ-034 Reset release with scan_en=1 -> ring_counter 001,010,100 each for 4 cycles; frame_done pulses every 12 cycles; cols=0.
REQ-035 Glyph 1 accepted mid-frame -> in_ready=0 until the boundary; cols become 7F/7F/7F only in the cycle ring_counter returns to 001.
REQ-036 Glyph 3 accepted on the boundary edge, then glyph 4 offered -> glyph 4 stalls; 3 appears at the next boundary (41/22/1C) and 4 at the one after.
REQ-037 Glyph 3 with blink=1 -> image shown for 2 frames, zero for 2 frames, repeating; glyph 9 -> blank.
REQ-038 scan_en dropped in phase 010 -> ring_counter=000 next cycle, no frame_done; re-enable -> 001 held for a full 4 cycles.
REQ-039 Reset asserted in phase 100 with a pending glyph -> all outputs at reset values immediately; in_ready=1; the next frame is blank.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - glyph codes, glyph ROM contents and scan phase constants
package matrix_pkg;

    localparam logic [3:0] GLYPH_BLANK   = 4'd0;
    localparam logic [3:0] GLYPH_FULL    = 4'd1;
    localparam logic [3:0] GLYPH_DROP    = 4'd2;
    localparam logic [3:0] GLYPH_ALARM_X = 4'd3;
    localparam logic [3:0] GLYPH_BAR     = 4'd4;

    typedef enum logic [2:0] {
        PHASE_0 = 3'b001,
        PHASE_1 = 3'b010,
        PHASE_2 = 3'b100
    } phase_t;

    typedef struct packed {
        logic [6:0] c2;
        logic [6:0] c1;
        logic [6:0] c0;
    } glyph_img_t;

    localparam glyph_img_t IMG_BLANK   = '{c2: 7'h00, c1: 7'h00, c0: 7'h00};
    localparam glyph_img_t IMG_FULL    = '{c2: 7'h7F, c1: 7'h7F, c0: 7'h7F};
    localparam glyph_img_t IMG_DROP    = '{c2: 7'h0C, c1: 7'h1E, c0: 7'h3F};
    localparam glyph_img_t IMG_ALARM_X = '{c2: 7'h41, c1: 7'h22, c0: 7'h1C};
    localparam glyph_img_t IMG_BAR     = '{c2: 7'h00, c1: 7'h00, c0: 7'h7F};

    // Codes 5-15 are reserved and render blank.
    function automatic glyph_img_t glyph_lookup(input logic [3:0] code);
        glyph_img_t img;
        case (code)
            GLYPH_FULL:    img = IMG_FULL;
            GLYPH_DROP:    img = IMG_DROP;
            GLYPH_ALARM_X: img = IMG_ALARM_X;
            GLYPH_BAR:     img = IMG_BAR;
            default:       img = IMG_BLANK;
        endcase
        return img;
    endfunction

endpackage

// File: rtl/matrix_glyph_rom.sv
// rtl/matrix_glyph_rom.sv - combinational 16-entry glyph code to column image decoder
module matrix_glyph_rom
    import matrix_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] img_2,
    output logic [6:0] img_1,
    output logic [6:0] img_0
);

    glyph_img_t img;

    assign img   = glyph_lookup(code);
    assign img_2 = img.c2;
    assign img_1 = img.c1;
    assign img_0 = img.c0;

endmodule

// File: rtl/matrix_scan_controller.sv
// rtl/matrix_scan_controller.sv - 3-phase column scanner with frame-synchronous glyph load and blink
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_glyph,
    input  logic       in_blink,
    output logic [2:0] ring_counter,
    output logic [6:0] col_2,
    output logic [6:0] col_1,
    output logic [6:0] col_0,
    output logic       frame_done
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    phase_t        phase_q, phase_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          en_q, en_d;
    logic [2:0]    ring_q, ring_d;
    logic          frame_done_q, frame_done_d;
    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    pend_glyph_q, pend_glyph_d;
    logic          pend_blink_q, pend_blink_d;
    logic [3:0]    act_glyph_q, act_glyph_d;
    logic          act_blink_q, act_blink_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [6:0]    col2_q, col1_q, col0_q;
    logic [6:0]    col2_d, col1_d, col0_d;
    logic [6:0]    img_2, img_1, img_0;
    logic          boundary;
    logic          accept;

    // Decode from the next active glyph so the new image lands with ring_counter=001.
    matrix_glyph_rom u_rom (
        .code  (act_glyph_d),
        .img_2 (img_2),
        .img_1 (img_1),
        .img_0 (img_0)
    );

    always_comb begin
        phase_d       = phase_q;
        dwell_d       = dwell_q;
        en_d          = en_q;
        pend_valid_d  = pend_valid_q;
        pend_glyph_d  = pend_glyph_q;
        pend_blink_d  = pend_blink_q;
        act_glyph_d   = act_glyph_q;
        act_blink_d   = act_blink_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        boundary      = 1'b0;
        accept        = in_valid && !pend_valid_q;

        if (!scan_en) begin
            dwell_d = '0;
            phase_d = PHASE_0;
            en_d    = 1'b0;
        end else if (!en_q) begin
            // First enabled cycle is dwell count 0 of phase 001, giving a full first column.
            en_d = 1'b1;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            case (phase_q)
                PHASE_0: phase_d = PHASE_1;
                PHASE_1: phase_d = PHASE_2;
                default: begin
                    phase_d  = PHASE_0;
                    boundary = 1'b1;
                end
            endcase
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        if (boundary && pend_valid_q) begin
            act_glyph_d   = pend_glyph_q;
            act_blink_d   = pend_blink_q;
            pend_valid_d  = 1'b0;
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (boundary) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Accept and load are exclusive: load needs pending full, accept needs it empty.
        if (accept) begin
            pend_glyph_d = in_glyph;
            pend_blink_d = in_blink;
            pend_valid_d = 1'b1;
        end

        frame_done_d = boundary;
        ring_d       = en_d ? phase_d : 3'b000;

        if (act_blink_d && blink_phase_d) begin
            col2_d = '0;
            col1_d = '0;
            col0_d = '0;
        end else begin
            col2_d = img_2;
            col1_d = img_1;
            col0_d = img_0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PHASE_0;
            dwell_q       <= '0;
            en_q          <= 1'b0;
            ring_q        <= 3'b000;
            frame_done_q  <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_glyph_q  <= GLYPH_BLANK;
            pend_blink_q  <= 1'b0;
            act_glyph_q   <= GLYPH_BLANK;
            act_blink_q   <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            col2_q        <= '0;
            col1_q        <= '0;
            col0_q        <= '0;
        end else begin
            phase_q       <= phase_d;
            dwell_q       <= dwell_d;
            en_q          <= en_d;
            ring_q        <= ring_d;
            frame_done_q  <= frame_done_d;
            pend_valid_q  <= pend_valid_d;
            pend_glyph_q  <= pend_glyph_d;
            pend_blink_q  <= pend_blink_d;
            act_glyph_q   <= act_glyph_d;
            act_blink_q   <= act_blink_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            col2_q        <= col2_d;
            col1_q        <= col1_d;
            col0_q        <= col0_d;
        end
    end

    assign in_ready     = !pend_valid_q;
    assign ring_counter = ring_q;
    assign frame_done   = frame_done_q;
    assign col_2        = col2_q;
    assign col_1        = col1_q;
    assign col_0        = col0_q;

endmodule
